// File: rtl/seg_scan_mux.sv
// Eight-digit seven-segment scan driver: frame-synchronous shadow capture, ghost blanking, per-digit blink.
// Outputs registered (one cycle after the scan position is taken); input changes visible next frame.
module seg_scan_mux #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_HALF   = 25000000
) (
    input  logic       clk,
    input  logic       ac,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic [7:0] seg4,
    input  logic [7:0] seg5,
    input  logic [7:0] seg6,
    input  logic [7:0] seg7,
    input  logic [7:0] blink_mask,
    output logic [7:0] seg_out,
    output logic [7:0] an,
    output logic       frame_tick
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] C_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);
    localparam logic [BW-1:0] B_LAST  = BW'(BLINK_HALF - 1);

    // Counters hold the scan position / blink state for the upcoming edge.
    logic [CW-1:0] c_q, c_d;
    logic [2:0]    d_q, d_d;
    logic [BW-1:0] bc_q, bc_d;
    logic          hidden_q, hidden_d;

    logic [7:0]    shadow_q [8];
    logic [7:0]    shadow_d [8];
    logic [7:0]    mask_q, mask_d;

    logic [7:0]    seg_out_q, seg_out_d;
    logic [7:0]    an_q, an_d;
    logic          tick_q, tick_d;

    logic [7:0]    seg_in [8];
    logic          frame_start;
    logic          c_wrap;
    logic          b_wrap;

    always_comb begin
        seg_in[0] = seg0;
        seg_in[1] = seg1;
        seg_in[2] = seg2;
        seg_in[3] = seg3;
        seg_in[4] = seg4;
        seg_in[5] = seg5;
        seg_in[6] = seg6;
        seg_in[7] = seg7;
    end

    always_comb begin
        frame_start = (c_q == '0) && (d_q == 3'd0);
        c_wrap      = (c_q == C_LAST);
        b_wrap      = (bc_q == B_LAST);

        c_d      = c_wrap ? '0 : c_q + 1'b1;
        d_d      = c_wrap ? d_q + 3'd1 : d_q;
        bc_d     = b_wrap ? '0 : bc_q + 1'b1;
        hidden_d = hidden_q ^ b_wrap;

        for (int k = 0; k < 8; k++) begin
            shadow_d[k] = frame_start ? seg_in[k] : shadow_q[k];
        end
        mask_d = frame_start ? blink_mask : mask_q;

        // Slot start is always blank, so the shadow read here is already settled.
        an_d      = 8'hFF;
        seg_out_d = 8'hFF;
        if (c_q >= C_BLANK) begin
            an_d = ~(8'b1 << d_q);
            if (!(mask_q[d_q] && hidden_q)) begin
                seg_out_d = shadow_q[d_q];
            end
        end
        tick_d = frame_start;
    end

    always_ff @(posedge clk) begin
        if (ac) begin
            c_q       <= '0;
            d_q       <= 3'd0;
            bc_q      <= '0;
            hidden_q  <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= 8'hFF;
            end
            mask_q    <= 8'h00;
            seg_out_q <= 8'hFF;
            an_q      <= 8'hFF;
            tick_q    <= 1'b0;
        end else begin
            c_q       <= c_d;
            d_q       <= d_d;
            bc_q      <= bc_d;
            hidden_q  <= hidden_d;
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            mask_q    <= mask_d;
            seg_out_q <= seg_out_d;
            an_q      <= an_d;
            tick_q    <= tick_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
